// File: rtl/common.sv
// Shared execute-stage types: data word and the count-leading-ones engine types.
package common;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CLO_CNT_W = 6;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [CLO_CNT_W-1:0] clo_cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } clo_state_t;

endpackage

// File: rtl/clo_byte.sv
// Combinational leading-ones count of one byte, MSB first; result 0..8.
module clo_byte (
    input  logic [7:0] data,
    output logic [3:0] count
);

    logic run;

    // Count ones from bit 7 down until the first zero.
    always_comb begin
        count = 4'd0;
        run   = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (run && data[i]) begin
                count = count + 4'd1;
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/count_lead_sched.sv
// Shared CLZ/CLO engine: round-robin arbitration of two issue slots onto one
// leading-ones counter, byte-serial scan from the MSB with early stop.
// Build option CLO_FAST_EN: full 32-bit count in a single SCAN cycle.
module count_lead_sched
    import common::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_clz,
    input  word_t       req_data0,
    input  word_t       req_data1,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output word_t       resp_data
);

    clo_state_t state;
    logic       rr_last;
    logic       tag;
    word_t      op;
    clo_cnt_t   cnt;

    logic       grant;
    word_t      sel_data;
    logic       sel_clz;
    clo_cnt_t   cnt_sum;
    logic       scan_last;

    // Round-robin grant and the accept strobe; flush or reset blocks acceptance.
    always_comb begin
        grant     = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
        sel_data  = grant ? req_data1 : req_data0;
        sel_clz   = req_clz[grant];
        req_ready = 2'b00;
        if (resetn && !flush && (state == IDLE) && (req_valid != 2'b00)) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

`ifdef CLO_FAST_EN
    logic [3:0] byte_ones [4];

    // One counter per byte; byte 3 holds the MSBs.
    for (genvar gb = 0; gb < 4; gb++) begin : g_byte
        clo_byte u_byte (
            .data  (op[8*gb +: 8]),
            .count (byte_ones[gb])
        );
    end

    // Prefix combine: a byte contributes only while every byte above it is all ones.
    always_comb begin
        logic run;
        cnt_sum   = cnt;
        run       = 1'b1;
        scan_last = 1'b1;
        for (int b = 3; b >= 0; b--) begin
            if (run) begin
                cnt_sum = cnt_sum + clo_cnt_t'(byte_ones[b]);
                run     = (byte_ones[b] == 4'd8);
            end
        end
    end
`else
    logic [1:0] idx;
    logic [7:0] scan_byte;
    logic [3:0] byte_ones;

    clo_byte u_byte (
        .data  (scan_byte),
        .count (byte_ones)
    );

    // Feed the current byte and stop on a partial byte or after the LSB byte.
    always_comb begin
        scan_byte = op[{idx, 3'b000} +: 8];
        cnt_sum   = cnt + clo_cnt_t'(byte_ones);
        scan_last = (byte_ones != 4'd8) || (idx == 2'd0);
    end
`endif

    // Control FSM with registered response; flush dominates every state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            rr_last    <= 1'b1;
            tag        <= 1'b0;
            op         <= '0;
            cnt        <= '0;
`ifndef CLO_FAST_EN
            idx        <= 2'd0;
`endif
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
        end else if (flush) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ready != 2'b00) begin
                        op    <= sel_clz ? ~sel_data : sel_data;
                        tag   <= grant;
                        cnt   <= '0;
`ifndef CLO_FAST_EN
                        idx   <= 2'd3;
`endif
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    cnt <= cnt_sum;
                    if (scan_last) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_id    <= tag;
                        resp_data  <= word_t'(cnt_sum);
                    end
`ifndef CLO_FAST_EN
                    else begin
                        idx <= idx - 2'd1;
                    end
`endif
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_last    <= tag;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_lead_sched.sv
// Scoreboard bench for count_lead_sched: expected responses are queued on
// accept and compared when the DUT presents them.
module tb_count_lead_sched;

    logic        clk        = 1'b0;
    logic        resetn     = 1'b0;
    logic        flush      = 1'b0;
    logic [1:0]  req_valid  = 2'b00;
    logic [1:0]  req_clz    = 2'b00;
    logic [31:0] req_data0  = '0;
    logic [31:0] req_data1  = '0;
    logic        resp_ready = 1'b1;
    logic [1:0]  req_ready;
    logic        resp_valid;
    logic        resp_id;
    logic [31:0] resp_data;

    count_lead_sched dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_clz    (req_clz),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic   id;
        int     cnt;
        longint due;
    } exp_t;

    exp_t   sb[$];
    int     grant_log[$];
    int     n_vec = 0;
    int     n_err = 0;
    longint cyc   = 0;
    logic   m_busy = 1'b0;
    logic   m_pending = 1'b0;
    logic   m_rr = 1'b1;
    logic   m_flush_prev = 1'b0;
    exp_t   cap;
    int     bp_mode = 0;
    int     rv_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lead_ones(input logic [31:0] v);
        int c = 0;
        for (int i = 31; i >= 0; i--) begin
            if (!v[i]) break;
            c++;
        end
        return c;
    endfunction

    function automatic int scan_bytes(input int c);
`ifdef CLO_FAST_EN
        return 1;
`else
        return (c / 8 + 1 > 4) ? 4 : c / 8 + 1;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Response-side backpressure: always ready, random, or hold off 3 cycles.
    always @(posedge clk) begin
        #1;
        if (resp_valid) rv_cnt++;
        else            rv_cnt = 0;
        case (bp_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = 1'($urandom_range(0, 1));
            default: resp_ready = (rv_cnt >= 4);
        endcase
    end

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin : mon
        logic [1:0]  exp_ready;
        logic        g;
        logic [31:0] d;
        int          c;
        exp_t        e;
        if (!resetn) begin
            m_busy       = 1'b0;
            m_pending    = 1'b0;
            m_rr         = 1'b1;
            m_flush_prev = 1'b0;
            sb.delete();
        end else begin
            g = (req_valid == 2'b11) ? ~m_rr : req_valid[1];
            exp_ready = (!m_busy && !flush && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            if (m_flush_prev) check("no_resp_after_flush", 32'(resp_valid), 32'd0);
            if (m_pending) begin
                check("resp_hold", 32'(resp_valid), 32'd1);
                check("hold_data", resp_data, 32'(cap.cnt));
                check("hold_id", 32'(resp_id), 32'(cap.id));
            end else if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    cap = sb.pop_front();
                    check("resp_data", resp_data, 32'(cap.cnt));
                    check("resp_id", 32'(resp_id), 32'(cap.id));
                    check("latency", 32'(cyc), 32'(cap.due));
                    m_pending = 1'b1;
                end
            end
            if (!m_pending && sb.size() != 0 && cyc > sb[0].due) begin
                check("resp_timeout", 32'd0, 32'd1);
                e = sb.pop_front();
                m_busy = 1'b0;
            end
            if (flush) begin
                if (m_busy && !m_pending && sb.size() != 0) e = sb.pop_front();
                m_busy    = 1'b0;
                m_pending = 1'b0;
            end else if (m_pending && resp_ready) begin
                m_rr      = cap.id;
                m_busy    = 1'b0;
                m_pending = 1'b0;
            end else if (exp_ready != 2'b00) begin
                d     = g ? req_data1 : req_data0;
                c     = lead_ones(req_clz[g] ? ~d : d);
                e.id  = g;
                e.cnt = c;
                e.due = cyc + 1 + longint'(scan_bytes(c));
                sb.push_back(e);
                grant_log.push_back(int'(g));
                m_busy = 1'b1;
            end
            m_flush_prev = flush;
        end
    end

    task automatic issue(input int slot, input logic clz, input logic [31:0] d);
        bit got = 1'b0;
        if (slot == 0) req_data0 = d;
        else           req_data1 = d;
        req_clz[slot]   = clz;
        req_valid[slot] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready[slot]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid[slot] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (!m_busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin : wdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] all_ones;
        logic [31:0] v;
        int          sh;
        int          slot;
        logic        clz;
        all_ones = '1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Directed counts: partial bytes, full width, zero, one below full.
        issue(0, 1'b0, 32'hFFFF_0F00); wait_idle();
        issue(1, 1'b1, 32'h0001_0000); wait_idle();
        issue(0, 1'b0, 32'hFFFF_FFFF); wait_idle();
        issue(1, 1'b1, 32'h0000_0000); wait_idle();
        issue(0, 1'b0, 32'h7FFF_FFFF); wait_idle();
        issue(0, 1'b0, 32'hFFFF_FFFE); wait_idle();
        issue(1, 1'b1, 32'h0000_0001); wait_idle();

        // Arbitration from reset with both slots held valid and slow consumer.
        do_reset();
        grant_log.delete();
        bp_mode   = 2;
        req_data0 = 32'hFF00_0000;
        req_data1 = 32'h0000_FFFF;
        req_clz   = 2'b10;
        req_valid = 2'b11;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (grant_log.size() >= 3) break;
        end
        req_valid = 2'b00;
        if (grant_log.size() >= 3) begin
            check("arb_grant0", 32'(grant_log[0]), 32'd0);
            check("arb_grant1", 32'(grant_log[1]), 32'd1);
            check("arb_grant2", 32'(grant_log[2]), 32'd0);
        end else begin
            check("arb_grants", 32'(grant_log.size()), 32'd3);
        end
        wait_idle();
        bp_mode = 0;
        req_clz = 2'b00;

        // Flush in the second SCAN cycle of a full-width count.
        issue(0, 1'b0, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("flushed_no_resp", 32'(resp_valid), 32'd0);
        end

        // Flush alongside a new request must block the accept.
        @(posedge clk);
        #1;
        flush        = 1'b1;
        req_data0    = 32'h8000_0000;
        req_clz[0]   = 1'b0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("flush_blocks_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        issue(0, 1'b0, 32'h8000_0000); wait_idle();

        // Random operands with a controlled leading run and random backpressure.
        bp_mode = 1;
        for (int n = 0; n < 24; n++) begin
            sh   = $urandom_range(0, 32);
            slot = $urandom_range(0, 1);
            clz  = 1'($urandom_range(0, 1));
            v    = ~(all_ones >> sh) | ($urandom & (all_ones >> (sh + 1)));
            issue(slot, clz, clz ? ~v : v);
            wait_idle();
        end
        bp_mode = 0;

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
